// File: rtl/count_sched.sv
// Round-robin owner of a shared 4-bit up-counter: grants it to one requester,
// clears it, and pulses that requester's done once the count reaches its length.
//
// state | meaning
// IDLE  | counter free; arbitrate among asserted requests
// CLEAR | counter granted; cnt_clr asserted for one cycle
// RUN   | waiting for cnt to equal the latched length
// DONE  | done pulse to owner; owner becomes the round-robin pointer
module count_sched #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [4*N-1:0] len,
  input  logic [3:0]     cnt,
  output logic           cnt_clr,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] ptr;
  logic [W-1:0] winner;
  logic [3:0]   len_q;

  logic [W-1:0] start_idx;
  logic [N-1:0] req_rot;
  logic [W-1:0] off;
  logic         found;
  logic [W:0]   sum;
  logic [W-1:0] pick;
  logic [3:0]   pick_len;
  logic [N-1:0] win_oh;

  // Rotate requests so the slot after the last winner sits at bit 0, then take the lowest set bit.
  always_comb begin
    int j;
    j         = 0;
    start_idx = (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
    req_rot   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(start_idx) + i;
      if (j >= N) j = j - N;
      req_rot[i] = req[j];
    end
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        off   = W'(i);
      end
    end
    sum      = {1'b0, start_idx} + {1'b0, off};
    pick     = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
    pick_len = len[{pick, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= W'(N - 1);
      winner <= '0;
      len_q  <= '0;
    end else begin
      if (state == IDLE && found) begin
        winner <= pick;
        len_q  <= pick_len;
      end
      if (state == DONE) ptr <= winner;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (cnt == len_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    win_oh  = {{(N-1){1'b0}}, 1'b1} << winner;
    grant   = '0;
    done    = '0;
    busy    = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      CLEAR: begin
        grant   = win_oh;
        busy    = 1'b1;
        cnt_clr = 1'b1;
      end
      RUN: begin
        grant = win_oh;
        busy  = 1'b1;
      end
      DONE: begin
        grant = win_oh;
        done  = win_oh;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: directed scenarios plus random traffic, checked every
// cycle against a timeline model of each grant (occupancy len+3, one idle gap).
module tb_count_sched;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [4*N-1:0] len;
  logic [3:0]     cnt;
  logic           cnt_clr;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  // model: owner (-1 idle), cycles since grant, latched length, last winner
  int m_owner;
  int m_pos;
  int m_len;
  int m_last;

  count_sched #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .cnt(cnt),
    .cnt_clr(cnt_clr), .grant(grant), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // shared counter: synchronous clear, free-running wrap
  always @(posedge clk) begin
    if (rst || cnt_clr) cnt <= 4'd0;
    else                cnt <= cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic           r;
    logic [N-1:0]   rq;
    logic [4*N-1:0] ln;
    logic [N-1:0]   exp_g;
    logic [N-1:0]   exp_d;
    bit             picked;
    r  = rst;
    rq = req;
    ln = len;
    @(posedge clk);
    #1;
    if (r) begin
      m_owner = -1;
      m_pos   = 0;
      m_len   = 0;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      picked = 0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (!picked && rq[idx]) begin
          picked  = 1;
          m_owner = idx;
          m_len   = int'(ln[4*idx +: 4]);
          m_pos   = 0;
        end
      end
    end else begin
      m_pos++;
      if (m_pos == m_len + 3) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    exp_g = '0;
    exp_d = '0;
    if (m_owner >= 0) begin
      exp_g[m_owner] = 1'b1;
      if (m_pos == m_len + 2) exp_d[m_owner] = 1'b1;
    end
    chk("grant", 32'(grant), 32'(exp_g));
    chk("done", 32'(done), 32'(exp_d));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("cnt_clr", 32'(cnt_clr), 32'(m_owner >= 0 && m_pos == 0));
    if (m_owner >= 0 && m_pos >= 1 && m_pos <= m_len + 1)
      chk("cnt_in_run", 32'(cnt), 32'(m_pos - 1));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_owner = -1;
    m_pos   = 0;
    m_len   = 0;
    m_last  = N - 1;
    rst = 1'b1;
    req = '0;
    len = '0;
    steps(2);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    steps(2);

    // single request, len0 = 3
    req = 4'b0001;
    len = 16'h0003;
    step();
    chk("single_grant_t1", 32'(grant), 32'h1);
    steps(5);
    chk("single_done_t6", 32'(done), 32'h1);
    req = '0;
    step();
    chk("single_busy_t7", 32'(busy), 32'd0);
    steps(4);

    // fairness, all len 0
    req = 4'b1111;
    len = 16'h0000;
    steps(22);
    req = '0;
    steps(8);

    // len 15 on requester 0
    req = 4'b0001;
    len = 16'h000F;
    step();
    req = '0;
    steps(17);
    chk("len15_done", 32'(done), 32'h1);
    steps(3);

    // requester 2 drops req and changes len during RUN
    req = 4'b0100;
    len = 16'h0500;
    steps(3);
    req = '0;
    len = 16'h0100;
    steps(5);
    chk("midchg_done", 32'(done), 32'h4);
    steps(3);

    // reset mid-interval, then pointer back at requester 0
    req = 4'b0001;
    len = 16'h0007;
    steps(4);
    rst = 1'b1;
    req = '0;
    step();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    req = 4'b1010;
    step();
    chk("rst_mid_winner", 32'(grant), 32'h2);
    req = '0;
    steps(8);

    // late requester 3 arrives while requester 0 runs
    req = 4'b0001;
    len = 16'h0004;
    steps(3);
    req = 4'b1000;
    steps(14);
    req = '0;
    steps(8);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) len = 16'($urandom);
      step();
    end
    rst = 1'b0;
    req = '0;
    steps(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
